// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Operands are registered on grant; result and flags are captured one cycle later.
`default_nettype none

module alu_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_0_i,
  input  logic [OP_SIZE-1:0]   req_op_0_i,
  input  logic [WORD_SIZE-1:0] req_a_0_i,
  input  logic [WORD_SIZE-1:0] req_b_0_i,
  output logic                 req_ready_0_o,
  output logic                 rsp_valid_0_o,
  output logic [WORD_SIZE-1:0] rsp_result_0_o,
  output logic [2:0]           rsp_flags_0_o,
  input  logic                 rsp_ready_0_i,
  input  logic                 req_valid_1_i,
  input  logic [OP_SIZE-1:0]   req_op_1_i,
  input  logic [WORD_SIZE-1:0] req_a_1_i,
  input  logic [WORD_SIZE-1:0] req_b_1_i,
  output logic                 req_ready_1_o,
  output logic                 rsp_valid_1_o,
  output logic [WORD_SIZE-1:0] rsp_result_1_o,
  output logic [2:0]           rsp_flags_1_o,
  input  logic                 rsp_ready_1_i,
  output logic [OP_SIZE-1:0]   alu_op_o,
  output logic [WORD_SIZE-1:0] alu_a_o,
  output logic [WORD_SIZE-1:0] alu_b_o,
  input  logic [WORD_SIZE-1:0] alu_out_i,
  input  logic [WORD_SIZE-1:0] alu_flags_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [OP_SIZE-1:0]   alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0] alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0] alu_b_q, alu_b_d;
  logic [WORD_SIZE-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [2:0]           flags0_q, flags0_d, flags1_q, flags1_d;

  logic grant_valid;
  logic grant_idx;
  logic rsp_ready_owner;
  logic unused_flags;

  assign unused_flags = ^alu_flags_i[WORD_SIZE-1:3];

  // On a tie the requester that did not win last time is served.
  assign grant_valid     = req_valid_0_i | req_valid_1_i;
  assign grant_idx       = (req_valid_0_i && req_valid_1_i) ? ~last_grant_q : req_valid_1_i;
  assign rsp_ready_owner = owner_q ? rsp_ready_1_i : rsp_ready_0_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      flags0_q     <= '0;
      flags1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      flags0_q     <= flags0_d;
      flags1_q     <= flags1_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    res0_d        = res0_q;
    res1_d        = res1_q;
    flags0_d      = flags0_q;
    flags1_d      = flags1_q;
    req_ready_0_o = 1'b0;
    req_ready_1_o = 1'b0;
    rsp_valid_0_o = 1'b0;
    rsp_valid_1_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready_0_o = ~grant_idx;
          req_ready_1_o = grant_idx;
          owner_d       = grant_idx;
          alu_op_d      = grant_idx ? req_op_1_i : req_op_0_i;
          alu_a_d       = grant_idx ? req_a_1_i : req_a_0_i;
          alu_b_d       = grant_idx ? req_b_1_i : req_b_0_i;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          res1_d   = alu_out_i;
          flags1_d = alu_flags_i[2:0];
        end else begin
          res0_d   = alu_out_i;
          flags0_d = alu_flags_i[2:0];
        end
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_0_o = ~owner_q;
        rsp_valid_1_o = owner_q;
        if (rsp_ready_owner) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_op_o       = alu_op_q;
  assign alu_a_o        = alu_a_q;
  assign alu_b_o        = alu_b_q;
  assign rsp_result_0_o = res0_q;
  assign rsp_result_1_o = res1_q;
  assign rsp_flags_0_o  = flags0_q;
  assign rsp_flags_1_o  = flags1_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model; the bench also plays the external ALU.
`default_nettype none

module tb_alu_arbiter;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v [2];
  logic [2:0]    op [2];
  logic [W-1:0]  a [2];
  logic [W-1:0]  b [2];
  logic          rr [2];
  logic          rdy [2];
  logic          rv [2];
  logic [W-1:0]  res [2];
  logic [2:0]    fl [2];
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b, alu_out, alu_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = (2*W)'(x) * (2*W)'(y);
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return ~x;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return x ^ y;
      3'd6: return p[W-1:0];
      default: return x >> y;
    endcase
  endfunction

  // Environment ALU: flags are {zero, a>=b, a==b}.
  assign alu_out   = alu_ref(alu_op, alu_a, alu_b);
  assign alu_flags = {{(W-3){1'b0}}, alu_out == '0, alu_a >= alu_b, alu_a == alu_b};

  alu_arbiter #(.WORD_SIZE(W), .OP_SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0_i(v[0]), .req_op_0_i(op[0]), .req_a_0_i(a[0]), .req_b_0_i(b[0]),
    .req_ready_0_o(rdy[0]), .rsp_valid_0_o(rv[0]), .rsp_result_0_o(res[0]),
    .rsp_flags_0_o(fl[0]), .rsp_ready_0_i(rr[0]),
    .req_valid_1_i(v[1]), .req_op_1_i(op[1]), .req_a_1_i(a[1]), .req_b_1_i(b[1]),
    .req_ready_1_o(rdy[1]), .rsp_valid_1_o(rv[1]), .rsp_result_1_o(res[1]),
    .rsp_flags_1_o(fl[1]), .rsp_ready_1_i(rr[1]),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_out_i(alu_out), .alu_flags_i(alu_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      v[k] = 0; op[k] = '0; a[k] = '0; b[k] = '0; rr[k] = 0;
    end
    rst_n = 0;
    #22;
    checks++;
    if ({rdy[0], rdy[1], rv[0], rv[1]} !== 4'b0) begin
      errors++; $display("FAIL reset_hs: got %b want 0000", {rdy[0], rdy[1], rv[0], rv[1]});
    end
    checks++;
    if ({res[0], res[1], fl[0], fl[1]} !== '0) begin
      errors++; $display("FAIL reset_rsp: got %h %h %b %b want zeros", res[0], res[1], fl[0], fl[1]);
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== '0) begin
      errors++; $display("FAIL reset_alu: got %h %h %h want zeros", alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single();
    tick();
    v[0] = 1; op[0] = 3'd0; a[0] = 16'd3; b[0] = 16'd4;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %b%b want 10", rdy[0], rdy[1]);
    end
    tick();
    v[0] = 0; rr[0] = 1;
    @(negedge clk);
    checks++;
    if (rv[0] !== 1'b0 || alu_a !== 16'd3 || alu_b !== 16'd4 || alu_op !== 3'd0) begin
      errors++; $display("FAIL single_exec: rv=%b alu=%h %h %h want 0 0 3 4", rv[0], alu_op, alu_a, alu_b);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rv[0] !== 1'b1 || res[0] !== 16'd7 || fl[0] !== 3'b000) begin
      errors++; $display("FAIL single_rsp: rv=%b res=%h fl=%b want 1 0007 000", rv[0], res[0], fl[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rv[0] !== 1'b0) begin
      errors++; $display("FAIL single_done: rv=%b want 0", rv[0]);
    end
    rr[0] = 0;
  endtask

  task automatic test_flags();
    tick();
    v[1] = 1; op[1] = 3'd1; a[1] = 16'd5; b[1] = 16'd5; rr[1] = 1;
    @(negedge clk);
    checks++;
    if (rdy[1] !== 1'b1 || rdy[0] !== 1'b0) begin
      errors++; $display("FAIL flags_ready: got %b%b want 01", rdy[0], rdy[1]);
    end
    tick();
    v[1] = 0;
    tick();
    @(negedge clk);
    checks++;
    if (rv[1] !== 1'b1 || rv[0] !== 1'b0 || res[1] !== 16'd0 || fl[1] !== 3'b111) begin
      errors++; $display("FAIL flags_rsp: rv=%b%b res=%h fl=%b want 01 0000 111", rv[0], rv[1], res[1], fl[1]);
    end
    tick();
    rr[1] = 0;
  endtask

  task automatic test_tie();
    rst_n = 0;
    tick();
    rst_n = 1;
    v[0] = 1; op[0] = 3'd4; a[0] = 16'h00F0; b[0] = 16'h000F;
    v[1] = 1; op[1] = 3'd6; a[1] = 16'h0100; b[1] = 16'h0100;
    rr[0] = 1; rr[1] = 1;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % 2;
      @(negedge clk);
      checks++;
      if (rdy[e] !== 1'b1 || rdy[1-e] !== 1'b0) begin
        errors++; $display("FAIL tie_grant%0d: ready=%b%b want owner %0d", g, rdy[0], rdy[1], e);
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (rv[e] !== 1'b1 || rv[1-e] !== 1'b0 ||
          res[e] !== (e == 0 ? 16'h00FF : 16'h0000) || fl[e] !== (e == 0 ? 3'b010 : 3'b111)) begin
        errors++; $display("FAIL tie_rsp%0d: rv=%b%b res=%h fl=%b", g, rv[0], rv[1], res[e], fl[e]);
      end
      tick();
    end
    v[0] = 0; v[1] = 0; rr[0] = 0; rr[1] = 0;
  endtask

  task automatic test_backpressure();
    v[0] = 1; op[0] = 3'd7; a[0] = 16'h8000; b[0] = 16'd4;
    v[1] = 1; op[1] = 3'd0; a[1] = 16'd1; b[1] = 16'd1;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
      errors++; $display("FAIL bp_grant: ready=%b%b want 10", rdy[0], rdy[1]);
    end
    tick();
    v[0] = 0;
    tick();
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rv[0] !== 1'b1 || res[0] !== 16'h0800 || fl[0] !== 3'b010 || rdy[0] !== 1'b0 || rdy[1] !== 1'b0) begin
        errors++; $display("FAIL bp_hold: rv=%b res=%h fl=%b ready=%b%b want 1 0800 010 00",
                           rv[0], res[0], fl[0], rdy[0], rdy[1]);
      end
      tick();
    end
    rr[0] = 1;
    tick();
    rr[0] = 0;
    @(negedge clk);
    checks++;
    if (rdy[1] !== 1'b1 || rv[0] !== 1'b0) begin
      errors++; $display("FAIL bp_release: ready1=%b rv0=%b want 1 0", rdy[1], rv[0]);
    end
    rr[1] = 1;
    tick();
    v[1] = 0;
    tick();
    tick();
    rr[1] = 0;
  endtask

  task automatic test_reset_mid();
    v[1] = 1; op[1] = 3'd0; a[1] = 16'd2; b[1] = 16'd2;
    @(negedge clk);
    checks++;
    if (rdy[1] !== 1'b1) begin
      errors++; $display("FAIL rmid_grant: ready1=%b want 1", rdy[1]);
    end
    tick();
    v[1] = 0; rr[1] = 1;
    #2 rst_n = 0;
    #1;
    checks++;
    if (alu_a !== '0 || alu_op !== '0 || rv[1] !== 1'b0 || res[1] !== '0) begin
      errors++; $display("FAIL rmid_async: alu_a=%h op=%h rv1=%b res1=%h want zeros", alu_a, alu_op, rv[1], res[1]);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rv[1] !== 1'b0 || res[1] !== '0) begin
        errors++; $display("FAIL rmid_replay: rv1=%b res1=%h want 0 0000", rv[1], res[1]);
      end
    end
    tick();
    v[0] = 1; op[0] = 3'd5; a[0] = 16'h1234; b[0] = 16'h00FF;
    v[1] = 1;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin
      errors++; $display("FAIL rmid_tie: ready=%b%b want 10", rdy[0], rdy[1]);
    end
    tick();
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 0;
    tick();
    tick();
    rr[0] = 0;
  endtask

  task automatic test_operand_hold();
    v[0] = 1; op[0] = 3'd0; a[0] = 16'd10; b[0] = 16'd1;
    tick();
    v[0] = 0; a[0] = 16'd99;
    @(negedge clk);
    checks++;
    if (alu_a !== 16'd10) begin
      errors++; $display("FAIL hold_alu_a: got %h want 000a", alu_a);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rv[0] !== 1'b1 || res[0] !== 16'd11) begin
      errors++; $display("FAIL hold_result: rv=%b res=%h want 1 000b", rv[0], res[0]);
    end
    rr[0] = 1;
    tick();
    rr[0] = 0;
  endtask

  // Reference: phase 0 = free, 1 = operation executing, 2 = response offered.
  task automatic test_random();
    int phase = 0;
    int owner = 0;
    int last  = 0;
    logic [W-1:0] exp_res = '0;
    logic [2:0]   exp_fl  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int  w;
      bit  any;
      bit  acc [2];
      @(negedge clk);
      any = (phase == 0) && (v[0] || v[1]);
      w   = (v[0] && v[1]) ? 1 - last : (v[1] ? 1 : 0);
      for (int k = 0; k < 2; k++) begin
        acc[k] = any && (w == k);
        checks++;
        if (rdy[k] !== acc[k]) begin
          errors++; $display("FAIL rnd_ready%0d cyc %0d: got %b want %b", k, cyc, rdy[k], acc[k]);
        end
        checks++;
        if (rv[k] !== (phase == 2 && owner == k)) begin
          errors++; $display("FAIL rnd_rsp_valid%0d cyc %0d: got %b want %b", k, cyc, rv[k], phase == 2 && owner == k);
        end
      end
      if (phase == 2) begin
        checks++;
        if (res[owner] !== exp_res || fl[owner] !== exp_fl) begin
          errors++; $display("FAIL rnd_result%0d cyc %0d: got %h/%b want %h/%b",
                             owner, cyc, res[owner], fl[owner], exp_res, exp_fl);
        end
      end
      if (any) begin
        exp_res = alu_ref(op[w], a[w], b[w]);
        exp_fl  = {exp_res == '0, a[w] >= b[w], a[w] == b[w]};
      end
      @(posedge clk);
      if (any) begin
        phase = 1; owner = w;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && rr[owner]) begin
        phase = 0; last = owner;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k] || !v[k]) begin
          v[k]  = ($urandom % 3) != 0;
          op[k] = 3'($urandom);
          a[k]  = W'($urandom);
          b[k]  = ($urandom % 2) ? W'($urandom % 20) : W'($urandom);
        end
        rr[k] = ($urandom % 2) != 0;
      end
    end
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_operand_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
